alu_ctrl_stage: RTL
===================

// Module: alu_ctrl_stage
// PURPOSE
//  Registered ALU-control stage between the main control unit and the ALU.
//  - Decodes 4-bit control opcode, plus funct for R-type, into a 4-bit ALU command.
//  - Carries both operands alongside the command.
//  - Decouples producer and ALU with valid/ready handshakes and a 2-entry buffer.
//  - Inserts multiplier recovery gaps after every MUL transfer.
// PARAMETERS
//  DATA_W   32  operand width (reg1/reg2/outreg1/outreg2)
//  DEPTH    2   buffer entries, power of 2, >=2
//  MUL_LAT  3   multiplier occupancy in cycles; >=1
// PORTS
//  clk              in   1       clock, all logic on posedge
//  rst              in   1       synchronous, active-high reset
//  in_valid         in   1       producer has op/funct/operands
//  in_ready         out  1       stage can accept (buffer not full)
//  Op_from_control  in   4       0 ADD,1 SUB,2 MUL,3 AND,4 OR,5 RTYPE, others illegal
//  fonction         in   6       funct field, used only when op==RTYPE
//  reg1, reg2       in   DATA_W  operands
//  out_valid        out  1       command/operands valid to ALU
//  out_ready        in   1       ALU accepts
//  ctrl_command     out  4       0 ADD,1 SUB,2 MUL,3 AND,4 OR,5 SLT,6 SLL,7 SRL
//  outreg1,outreg2  out  DATA_W  operands matching ctrl_command
//  illegal          out  1       entry at output was undecodable (command forced ADD)
// BEHAVIOUR
//  - Reset: buffer empty; in_ready=1; out_valid=0; ctrl_command=0; outreg1/2=0; illegal=0; gap counter=0.
//  - Accept on in_valid&&in_ready. Decode happens at accept; the buffer stores {cmd,illegal,reg1,reg2}.
//  - RTYPE funct map: 0x20 ADD, 0x22 SUB, 0x18 MUL, 0x24 AND, 0x25 OR, 0x2A SLT, 0x00 SLL, 0x02 SRL.
//  - Unknown op or funct -> cmd ADD, illegal=1. The entry still flows; it is not dropped.
//  - Latency: accept at cycle N -> out_valid at N+1 at the earliest (empty buffer, no gap).
//  - Outputs hold stable while out_valid&&!out_ready. Strict FIFO order.
//  - in_ready = !full. Simultaneous accept and transfer when full is NOT allowed (in_ready=0); when not full, both occur and count is unchanged.
//  - Pointers wrap mod DEPTH; count is 0..DEPTH.
//  - MUL gap, FSM {RUN, GAP}:
//      RUN -> GAP when the transferred entry is MUL and MUL_LAT>1; load counter with MUL_LAT-1.
//      GAP: out_valid=0, counter decrements each cycle, buffer still accepts. GAP -> RUN when counter hits 0 at the same edge.
//      MUL_LAT==1: never enters GAP.
//  - rst asserted mid-operation discards all buffered entries and any gap in progress; next cycle equals the reset state.
//  - Data outputs are don't-care but held when out_valid=0 (no X toggling).
// CONFIGURATION
//  - ALU_CTRL_SHIFT_EN defined: SLT/SLL/SRL funct decode to commands 5/6/7.
//  - Not defined: funct 0x2A/0x00/0x02 decode as illegal (cmd ADD, illegal=1); commands 5-7 are never produced.
// STRUCTURE
//  - alu_ctrl_pkg: opcode constants (OP_ADD..OP_RTYPE), funct constants, ALU command constants, command width.
//  - Sub-module alu_ctrl_decode: combinational {op,funct} -> {cmd,illegal}, honours ALU_CTRL_SHIFT_EN.
//  - Top holds the buffer, the handshake and the gap FSM.
// TESTING
//  1. Reset, then op=0 reg1=5 reg2=7 with out_ready=1 -> next cycle out_valid=1, cmd=0, outreg1=5, outreg2=7, illegal=0.
//  2. op=5 with funct 0x22/0x24/0x25/0x18 back-to-back -> cmds 1,3,4,2 in order; funct 0x3F -> cmd 0, illegal=1.
//  3. out_ready=0, push 3 ops -> in_ready=0 after 2 accepts; 3rd held. Release out_ready -> order preserved, no loss or duplication.
//  4. MUL_LAT=3: MUL then ADD, out_ready=1 -> MUL transferred, out_valid=0 for exactly 2 cycles, then ADD.
//  5. Two entries buffered, assert rst 1 cycle -> out_valid=0, in_ready=1 next cycle; buffered entries never appear.
//  6. funct 0x00, both macro builds -> EN: cmd=6, illegal=0; not EN: cmd=0, illegal=1.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: opcode, funct and ALU command encodings shared by the ALU-control stage.
package alu_ctrl_pkg;
    localparam int CMD_W = 4;
    localparam int OP_W = 4;
    localparam int FUNCT_W = 6;

    localparam logic [OP_W-1:0] OP_ADD   = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB   = 4'd1;
    localparam logic [OP_W-1:0] OP_MUL   = 4'd2;
    localparam logic [OP_W-1:0] OP_AND   = 4'd3;
    localparam logic [OP_W-1:0] OP_OR    = 4'd4;
    localparam logic [OP_W-1:0] OP_RTYPE = 4'd5;

    localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
    localparam logic [FUNCT_W-1:0] FN_MUL = 6'h18;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;
    localparam logic [FUNCT_W-1:0] FN_SLL = 6'h00;
    localparam logic [FUNCT_W-1:0] FN_SRL = 6'h02;

    localparam logic [CMD_W-1:0] CMD_ADD = 4'd0;
    localparam logic [CMD_W-1:0] CMD_SUB = 4'd1;
    localparam logic [CMD_W-1:0] CMD_MUL = 4'd2;
    localparam logic [CMD_W-1:0] CMD_AND = 4'd3;
    localparam logic [CMD_W-1:0] CMD_OR  = 4'd4;
    localparam logic [CMD_W-1:0] CMD_SLT = 4'd5;
    localparam logic [CMD_W-1:0] CMD_SLL = 4'd6;
    localparam logic [CMD_W-1:0] CMD_SRL = 4'd7;

    typedef enum logic {ST_RUN, ST_GAP} state_e;
endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: {op,funct} -> {cmd,illegal}; shift/compare functs only when ALU_CTRL_SHIFT_EN is defined.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [OP_W-1:0]    op_i,
    input  logic [FUNCT_W-1:0] funct_i,
    output logic [CMD_W-1:0]   cmd_o,
    output logic               illegal_o
);
    always_comb begin
        cmd_o = CMD_ADD;
        illegal_o = 1'b0;
        case (op_i)
            OP_ADD: cmd_o = CMD_ADD;
            OP_SUB: cmd_o = CMD_SUB;
            OP_MUL: cmd_o = CMD_MUL;
            OP_AND: cmd_o = CMD_AND;
            OP_OR:  cmd_o = CMD_OR;
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADD: cmd_o = CMD_ADD;
                    FN_SUB: cmd_o = CMD_SUB;
                    FN_MUL: cmd_o = CMD_MUL;
                    FN_AND: cmd_o = CMD_AND;
                    FN_OR:  cmd_o = CMD_OR;
`ifdef ALU_CTRL_SHIFT_EN
                    FN_SLT: cmd_o = CMD_SLT;
                    FN_SLL: cmd_o = CMD_SLL;
                    FN_SRL: cmd_o = CMD_SRL;
`endif
                    default: illegal_o = 1'b1;
                endcase
            end
            default: illegal_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/alu_ctrl_stage.sv
// alu_ctrl_stage: decode-at-accept buffer with valid/ready handshakes and MUL recovery gaps.
// Shift/compare decode is enabled by defining ALU_CTRL_SHIFT_EN.
module alu_ctrl_stage
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 2,
    parameter int MUL_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   Op_from_control,
    input  logic [FUNCT_W-1:0] fonction,
    input  logic [DATA_W-1:0] reg1,
    input  logic [DATA_W-1:0] reg2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CMD_W-1:0]  ctrl_command,
    output logic [DATA_W-1:0] outreg1,
    output logic [DATA_W-1:0] outreg2,
    output logic              illegal
);
    localparam int PW = $clog2(DEPTH);
    localparam int NW = PW + 1;
    localparam int CW = $clog2(MUL_LAT + 1);

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic              ill;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } entry_t;

    entry_t         mem_q [DEPTH];
    logic [PW-1:0]  wr_q, rd_q;
    logic [NW-1:0]  cnt_q, cnt_d;
    state_e         state_q;
    logic [CW-1:0]  gap_q;
    logic [CMD_W-1:0] dec_cmd;
    logic           dec_ill;
    logic           push, pop;

    alu_ctrl_decode u_dec (
        .op_i     (Op_from_control),
        .funct_i  (fonction),
        .cmd_o    (dec_cmd),
        .illegal_o(dec_ill)
    );

    assign in_ready     = cnt_q != NW'(DEPTH);
    assign out_valid    = (cnt_q != '0) && (state_q == ST_RUN);
    assign push         = in_valid && in_ready;
    assign pop          = out_valid && out_ready;
    assign ctrl_command = mem_q[rd_q].cmd;
    assign illegal      = mem_q[rd_q].ill;
    assign outreg1      = mem_q[rd_q].a;
    assign outreg2      = mem_q[rd_q].b;

    always_comb begin
        cnt_d = cnt_q + NW'(push) - NW'(pop);
    end

    // Storage is cleared on reset so the head-driven outputs read zero until the first accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            state_q <= ST_RUN;
            gap_q   <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= '{cmd: dec_cmd, ill: dec_ill, a: reg1, b: reg2};
                wr_q        <= wr_q + PW'(1);
            end
            if (pop) rd_q <= rd_q + PW'(1);
            cnt_q <= cnt_d;
            if (state_q == ST_RUN) begin
                if (pop && ctrl_command == CMD_MUL && MUL_LAT > 1) begin
                    state_q <= ST_GAP;
                    gap_q   <= CW'(MUL_LAT - 1);
                end
            end else begin
                gap_q <= gap_q - CW'(1);
                if (gap_q == CW'(1)) state_q <= ST_RUN;
            end
        end
    end
endmodule
